// File: rtl/axis_snooper_pkg.sv
// axis_snooper_pkg: shared state encoding and sizing helpers for the AXI-Stream snooper.
package axis_snooper_pkg;
    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    typedef enum logic [1:0] {
        SYNC    = ST_SYNC,
        IDLE    = ST_IDLE,
        CAPTURE = ST_CAPTURE,
        DROP    = ST_DROP
    } state_t;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/keep_popcount.sv
// keep_popcount: counts set TKEEP bits, contiguous or not.
module keep_popcount #(
    parameter int KEEP_WIDTH = 8,
    parameter int INC_WIDTH  = 8
) (
    input  logic [KEEP_WIDTH-1:0] i_keep,
    output logic [INC_WIDTH-1:0]  o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++)
            o_count = o_count + INC_WIDTH'(i_keep[i]);
    end
endmodule

// File: rtl/axis_snooper.sv
// axis_snooper: passively captures AXI-Stream packets into an arbitrated packet buffer,
// dropping and counting packets that start while no buffer is free.
module axis_snooper
    import axis_snooper_pkg::*;
#(
    parameter int PACKMEM_ADDR_WIDTH = 8,
    parameter int PACKMEM_DATA_WIDTH = 64,
    parameter int INC_WIDTH          = 8,
    parameter int DROP_CNT_WIDTH     = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [PACKMEM_DATA_WIDTH-1:0]                sn_TDATA,
    input  logic [keep_width(PACKMEM_DATA_WIDTH)-1:0]    sn_TKEEP,
    input  logic                                         sn_TLAST,
    input  logic                                         sn_TVALID,
    input  logic                                         sn_TREADY,
    input  logic                                         rdy,
    output logic                                         ack,
    output logic [PACKMEM_ADDR_WIDTH-1:0]                addr,
    output logic [PACKMEM_DATA_WIDTH-1:0]                wr_data,
    output logic                                         wr_en,
    output logic [INC_WIDTH-1:0]                         byte_inc,
    output logic                                         done,
    output logic                                         drop_pulse,
    output logic [DROP_CNT_WIDTH-1:0]                    drop_cnt
);
    localparam int KW = keep_width(PACKMEM_DATA_WIDTH);

    state_t                        r_state;
    logic [PACKMEM_ADDR_WIDTH-1:0] r_next;
    logic                          r_full;
    logic                          w_beat;
    logic                          w_cap;
    logic                          w_wr;
    logic                          w_drop;
    logic [INC_WIDTH-1:0]          w_inc;

    keep_popcount #(.KEEP_WIDTH(KW), .INC_WIDTH(INC_WIDTH)) u_pop (
        .i_keep  (sn_TKEEP),
        .o_count (w_inc)
    );

    assign w_beat = sn_TVALID && sn_TREADY;
    assign ack    = r_state == IDLE && w_beat && rdy;
    assign w_drop = r_state == IDLE && w_beat && !rdy;
    assign w_cap  = r_state == CAPTURE && w_beat;
    assign w_wr   = ack || (w_cap && !r_full);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SYNC;
            r_next     <= '0;
            r_full     <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            byte_inc   <= '0;
            done       <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wr_en      <= w_wr;
            done       <= w_beat && sn_TLAST && (ack || r_state == CAPTURE);
            drop_pulse <= w_drop;
            if (w_drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            if (w_wr) begin
                addr     <= ack ? '0 : r_next;
                wr_data  <= sn_TDATA;
                byte_inc <= w_inc;
            end
            // r_full latches once the top word is written, so addresses never wrap
            if (ack) begin
                r_next <= PACKMEM_ADDR_WIDTH'(1);
                r_full <= 1'b0;
            end else if (w_cap && !r_full) begin
                if (r_next == '1)
                    r_full <= 1'b1;
                else
                    r_next <= r_next + PACKMEM_ADDR_WIDTH'(1);
            end
            if (w_beat)
                r_state <= sn_TLAST ? IDLE : (r_state == IDLE ? (rdy ? CAPTURE : DROP) : r_state);
        end
    end
endmodule
